// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch slice: default widths, reset PC
// and the fetch FSM state encoding.
package fetch_pkg;

  localparam int unsigned FETCH_DATA_W   = 16;
  localparam int unsigned FETCH_ADDR_W   = 16;
  localparam int unsigned FETCH_RESET_PC = 0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO of {pc, instr} between the fetch stage and decode.
// Entry 0 is always the head; flush empties it regardless of push/pop.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_W = FETCH_DATA_W,
  parameter int unsigned ADDR_W = FETCH_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_pc,
  output logic [1:0]        count,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data,
  output logic [ADDR_W-1:0] head_pc
);

  logic [DATA_W-1:0] data [2];
  logic [ADDR_W-1:0] pcs  [2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      data[0] <= '0;
      data[1] <= '0;
      pcs[0]  <= '0;
      pcs[1]  <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            data[0] <= push_data;
            pcs[0]  <= push_pc;
            count   <= 2'd1;
          end else if (count == 2'd1) begin
            data[1] <= push_data;
            pcs[1]  <= push_pc;
            count   <= 2'd2;
          end
        end
        2'b01: begin
          data[0] <= data[1];
          pcs[0]  <= pcs[1];
          count   <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; with two entries the second slides to the head.
          if (count == 2'd2) begin
            data[0] <= data[1];
            pcs[0]  <= pcs[1];
            data[1] <= push_data;
            pcs[1]  <= push_pc;
          end else begin
            data[0] <= push_data;
            pcs[0]  <= push_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_valid = (count != 2'd0);
  assign head_data  = data[0];
  assign head_pc    = pcs[0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives InstrMemory, tracks the in-flight read and
// buffers returned words for decode. Optional FETCH_BOUNDS_CHECK_EN adds fetch_fault.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_W   = FETCH_DATA_W,
  parameter int unsigned ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned RESET_PC = FETCH_RESET_PC
`ifdef FETCH_BOUNDS_CHECK_EN
  , parameter int unsigned MEM_DEPTH = 128
`endif
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
`ifdef FETCH_BOUNDS_CHECK_EN
  , output logic            fetch_fault
`endif
);

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic              inflight, inflight_n;
  logic [ADDR_W-1:0] inflight_pc;
  logic [1:0]        count;
  logic [2:0]        occ;
  logic              pop, room, issue_ok, issue;
`ifdef FETCH_BOUNDS_CHECK_EN
  logic              oob, redir_oob;
`endif

  always_comb begin
    pop      = instr_valid & instr_ready;
    occ      = 3'(count) + 3'(inflight);
    room     = pop ? (occ < 3'd3) : (occ < 3'd2);
    // HOLD releases in the same cycle room appears, so a resumed stall keeps 1 instr/cycle.
    issue_ok = room && (state == FETCH || state == HOLD);
`ifdef FETCH_BOUNDS_CHECK_EN
    oob       = 32'(pc) >= MEM_DEPTH;
    redir_oob = 32'(redirect_pc) >= MEM_DEPTH;
    issue     = issue_ok && !oob;
`else
    issue     = issue_ok;
`endif
    state_n    = state;
    pc_n       = pc;
    inflight_n = 1'b0;
    if (redirect_valid) begin
      pc_n    = redirect_pc;
      state_n = FETCH;
`ifdef FETCH_BOUNDS_CHECK_EN
      if (state == FAULT && redir_oob) state_n = FAULT;
`endif
    end else begin
      if (issue) begin
        pc_n       = pc + ADDR_W'(1);
        inflight_n = 1'b1;
      end
`ifdef FETCH_BOUNDS_CHECK_EN
      if (issue_ok && oob) state_n = FAULT;
      else
`endif
      if (state == FETCH && !room) state_n = HOLD;
      else if (state == HOLD && room) state_n = FETCH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= ADDR_W'(RESET_PC);
      inflight    <= 1'b0;
      inflight_pc <= '0;
`ifdef FETCH_BOUNDS_CHECK_EN
      fetch_fault <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      inflight <= inflight_n;
      if (issue) inflight_pc <= pc;
`ifdef FETCH_BOUNDS_CHECK_EN
      fetch_fault <= (state_n == FAULT);
`endif
    end
  end

  assign imem_addr = pc;

  fetch_skid_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (inflight),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_data  (imem_data),
    .push_pc    (inflight_pc),
    .count      (count),
    .head_valid (instr_valid),
    .head_data  (instr),
    .head_pc    (instr_pc)
  );

endmodule
